updown_mod_counter: RTL and testbench



---
 rtl/updown_mod_counter.sv | 92 +++++++++
 tb/tb_updown_mod_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with enable, parallel load, async and sync clear,
// terminal-count/cascade outputs and a registered wrap pulse.
// Optional build macro: UDCOUNTER_SAT_EN selects saturating mode, where a count
// past an end holds the value and pulses wrap_o as an overflow/underflow flag.
// Cascade by driving the next stage's en_i from this stage's tco_o.
module updown_mod_counter #(
    parameter int unsigned N   = 4,
    parameter int unsigned MOD = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,       // asynchronous active-low clear
    input  logic         clr_sync_ni,  // synchronous active-low clear
    input  logic         en_i,
    input  logic         up_i,
    input  logic         ld_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         tc_o,
    output logic         tco_o,
    output logic         wrap_o
);

    // The modulus is held in N+1 bits so a modulus of 2**N compares correctly against a load value.
    localparam logic [N:0]   ModW  = (N+1)'(MOD);
    localparam logic [N-1:0] MaxQ  = N'(MOD - 1);
    localparam logic [N-1:0] ZeroQ = '0;
    localparam logic [N-1:0] OneQ  = N'(1);

    logic [N-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         at_top, at_zero;

    assign at_top  = (q_q == MaxQ);
    assign at_zero = (q_q == ZeroQ);

    // Terminal count and cascade carry/borrow, purely combinational.
    always_comb begin
        tc_o  = up_i ? at_top : at_zero;
        tco_o = tc_o & en_i;
    end

    // Next-state selection in priority order: sync clear, load, count, hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!clr_sync_ni) begin
            q_d = ZeroQ;
        end else if (ld_i) begin
            q_d = ({1'b0, d_i} < ModW) ? d_i : MaxQ;
        end else if (en_i) begin
            if (up_i) begin
                if (at_top) begin
                    wrap_d = 1'b1;
`ifdef UDCOUNTER_SAT_EN
                    q_d    = q_q;
`else
                    q_d    = ZeroQ;
`endif
                end else begin
                    // q_q < MOD-1 <= 2**N-1 here, so the N-bit sum cannot overflow.
                    q_d = q_q + OneQ;
                end
            end else begin
                if (at_zero) begin
                    wrap_d = 1'b1;
`ifdef UDCOUNTER_SAT_EN
                    q_d    = q_q;
`else
                    q_d    = MaxQ;
`endif
                end else begin
                    q_d = q_q - OneQ;
                end
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= ZeroQ;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a decade units stage cascaded into a
// decade tens stage. Honours UDCOUNTER_SAT_EN when defined at compile time.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_sync_n;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;
    logic [3:0] uq, tq;
    logic       utc, utco, uwrap;
    logic       ttc, ttco, twrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.N(4), .MOD(10)) u_units (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_sync_ni (clr_sync_n),
        .en_i        (en),
        .up_i        (up),
        .ld_i        (ld),
        .d_i         (d),
        .q_o         (uq),
        .tc_o        (utc),
        .tco_o       (utco),
        .wrap_o      (uwrap)
    );

    updown_mod_counter #(.N(4), .MOD(10)) u_tens (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_sync_ni (clr_sync_n),
        .en_i        (utco),
        .up_i        (up),
        .ld_i        (1'b0),
        .d_i         (4'd0),
        .q_o         (tq),
        .tc_o        (ttc),
        .tco_o       (ttco),
        .wrap_o      (twrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eu, et;
        logic ew;
        rst_n      = 1'b0;
        clr_sync_n = 1'b1;
        en         = 1'b0;
        up         = 1'b1;
        ld         = 1'b0;
        d          = 4'd0;
        #12;
        chk("reset_q", 32'(uq), 32'd0);
        chk("reset_wrap", 32'(uwrap), 32'd0);
        chk("reset_tc", 32'(utc), 32'd0);     // tc = ~up
        chk("reset_tco", 32'(utco), 32'd0);
        up = 1'b0;
        #1;
        chk("reset_tc_down", 32'(utc), 32'd1);
        en = 1'b1;
        #1;
        chk("reset_tco_down", 32'(utco), 32'd1);
        en = 1'b0;
        up = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Count up 12 edges from 0.
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
`ifdef UDCOUNTER_SAT_EN
            eu = (i >= 9) ? 9 : i;
            ew = (i >= 10);
`else
            eu = i % 10;
            ew = (i == 10);
`endif
            step();
            chk($sformatf("up_q_%0d", i), 32'(uq), 32'(eu));
            chk($sformatf("up_wrap_%0d", i), 32'(uwrap), 32'(ew));
            chk($sformatf("up_tc_%0d", i), 32'(utc), 32'(eu == 9));
        end

        // Synchronous clear, then count down from 0.
        clr_sync_n = 1'b0;
        step();
        chk("sclr_q", 32'(uq), 32'd0);
        chk("sclr_wrap", 32'(uwrap), 32'd0);
        clr_sync_n = 1'b1;
        up = 1'b0;
        #1;
        chk("down_tc_at0", 32'(utc), 32'd1);
        for (int i = 1; i <= 3; i++) begin
`ifdef UDCOUNTER_SAT_EN
            eu = 0;
            ew = 1'b1;
`else
            eu = 10 - i;
            ew = (i == 1);
`endif
            step();
            chk($sformatf("down_q_%0d", i), 32'(uq), 32'(eu));
            chk($sformatf("down_wrap_%0d", i), 32'(uwrap), 32'(ew));
            chk($sformatf("down_tc_%0d", i), 32'(utc), 32'(eu == 0));
        end

        // Load with clamp, and load overriding count.
        en = 1'b0;
        up = 1'b1;
        ld = 1'b1;
        d  = 4'd13;
        step();
        chk("ld_clamp_q", 32'(uq), 32'd9);
        chk("ld_clamp_wrap", 32'(uwrap), 32'd0);
        en = 1'b1;
        d  = 4'd5;
        step();
        chk("ld_over_en_q", 32'(uq), 32'd5);
        d = 4'd6;
        step();
        chk("ld6_q", 32'(uq), 32'd6);

        // Sync clear beats load.
        clr_sync_n = 1'b0;
        d = 4'd3;
        step();
        chk("sclr_over_ld_q", 32'(uq), 32'd0);
        clr_sync_n = 1'b1;

        // Async clear mid-cycle at q=7.
        d = 4'd7;
        en = 1'b0;
        step();
        chk("ld7_q", 32'(uq), 32'd7);
        ld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("aclr_q7", 32'(uq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async clear while wrap is high.
        ld = 1'b1;
        d  = 4'd9;
        step();
        ld = 1'b0;
        en = 1'b1;
        step();
        chk("pre_aclr_wrap", 32'(uwrap), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("aclr_q", 32'(uq), 32'd0);
        chk("aclr_wrap", 32'(uwrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_aclr_q", 32'(uq), 32'd1);

`ifndef UDCOUNTER_SAT_EN
        // Two-stage cascade, 100 edges from reset.
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        up = 1'b1;
        eu = 0;
        et = 0;
        ew = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            ew = (eu == 9) && (et == 9);
            if (eu == 9) et = (et == 9) ? 0 : et + 1;
            eu = (eu == 9) ? 0 : eu + 1;
            step();
            chk($sformatf("casc_units_%0d", i), 32'(uq), 32'(eu));
            chk($sformatf("casc_tens_%0d", i), 32'(tq), 32'(et));
        end
        chk("casc_final_units", 32'(uq), 32'd0);
        chk("casc_final_tens", 32'(tq), 32'd0);
        chk("casc_tens_wrap", 32'(twrap), 32'(ew));
        chk("casc_tens_wrap_set", 32'(twrap), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
